sha256_link_host: RTL and testbench

Host-side driver for the byte-serial SHA-256 hasher link. It buffers one message from an upstream valid/ready byte stream and replays it to the hasher as one contiguous strobed burst. It then captures the 32-byte digest the hasher returns and streams that digest downstream under valid/ready flow control. It sits between the system's message source and the hasher's `ui_in`/`uio_in[0]`/`uo_out`/`uio_out[1]` pins.

---
 rtl/sha256_link_host_if.sv | 36 +++
 rtl/sha256_link_host.sv | 140 ++++++++++++++
 tb/tb_sha256_link_host.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_link_host_if.sv
`default_nettype none
// ============================================================================
// Module   : sha256_link_host_if
// Brief    : Message, hasher-link, digest and status signals of sha256_link_host.
// Revision : 1.0 - initial release
// ============================================================================
interface sha256_link_host_if;
    logic [7:0] msg_data;
    logic       msg_valid;
    logic       msg_last;
    logic       msg_ready;
    logic [7:0] link_data;
    logic       link_valid;
    logic [7:0] link_dig;
    logic       link_flag;
    logic [7:0] dig_data;
    logic       dig_valid;
    logic       dig_last;
    logic       dig_ready;
    logic       busy;
    logic       err_len;
    logic       err_timeout;

    modport master (
        input  msg_data, msg_valid, msg_last, link_dig, link_flag, dig_ready,
        output msg_ready, link_data, link_valid, dig_data, dig_valid, dig_last,
        output busy, err_len, err_timeout
    );

    modport slave (
        output msg_data, msg_valid, msg_last, link_dig, link_flag, dig_ready,
        input  msg_ready, link_data, link_valid, dig_data, dig_valid, dig_last,
        input  busy, err_len, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/sha256_link_host.sv
`default_nettype none
// ============================================================================
// Module   : sha256_link_host
// Brief    : Buffers one message, bursts it to the byte-serial SHA-256 hasher,
//            captures the 32-byte digest and streams it downstream.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_link_host #(
    parameter int MAX_LEN = 55,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    sha256_link_host_if.master   bus
);
    localparam int         c_IW      = $clog2(MAX_LEN);
    localparam int         c_TW      = $clog2(TIMEOUT + 1);
    localparam logic [6:0] c_MAX     = 7'(MAX_LEN);
    localparam logic [6:0] c_MAXP1   = 7'(MAX_LEN + 1);
    localparam logic [c_TW-1:0] c_TMO_M1 = c_TW'(TIMEOUT - 1);

    localparam logic [2:0] S_COLLECT = 3'd0;
    localparam logic [2:0] S_SEND    = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    logic [2:0]      r_state;
    logic [6:0]      r_len;
    logic [6:0]      r_idx;
    logic [4:0]      r_cnt;
    logic [c_TW-1:0] r_tmr;
    logic            r_err_len;
    logic            r_err_timeout;
    logic [7:0]      r_buf  [MAX_LEN];
    logic [7:0]      r_dbuf [32];

    logic       w_hs;
    logic [6:0] w_len_inc;
    logic       w_len_ok;
    logic       w_store;

    assign w_hs      = (r_state == S_COLLECT) && bus.msg_valid;
    // Saturating at MAX_LEN+1 is enough to remember that the message overflowed.
    assign w_len_inc = (r_len >= c_MAXP1) ? r_len : r_len + 7'd1;
    assign w_len_ok  = (w_len_inc != 7'd0) && (w_len_inc <= c_MAX);
    assign w_store   = w_hs && (r_len < c_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_COLLECT;
            r_len         <= 7'd0;
            r_idx         <= 7'd0;
            r_cnt         <= 5'd0;
            r_tmr         <= '0;
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
            case (r_state)
                S_COLLECT: begin
                    if (w_hs) begin
                        if (bus.msg_last && w_len_ok) begin
                            r_len   <= w_len_inc;
                            r_idx   <= 7'd0;
                            r_state <= S_SEND;
                        end else if (bus.msg_last) begin
                            r_len     <= 7'd0;
                            r_err_len <= 1'b1;
                        end else begin
                            r_len <= w_len_inc;
                        end
                    end
                end
                S_SEND: begin
                    if (r_idx == r_len - 7'd1) begin
                        r_tmr   <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_idx <= r_idx + 7'd1;
                    end
                end
                S_WAIT: begin
                    if (bus.link_flag) begin
                        r_cnt   <= 5'd1;
                        r_state <= S_CAPTURE;
                    end else if (r_tmr == c_TMO_M1) begin
                        r_err_timeout <= 1'b1;
                        r_len         <= 7'd0;
                        r_state       <= S_COLLECT;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (r_cnt == 5'd31) begin
                        r_cnt   <= 5'd0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_DRAIN: begin
                    if (bus.dig_ready) begin
                        if (r_cnt == 5'd31) begin
                            r_cnt   <= 5'd0;
                            r_len   <= 7'd0;
                            r_state <= S_COLLECT;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked by r_len / r_state.
    always_ff @(posedge clk) begin
        if (w_store)
            r_buf[r_len[c_IW-1:0]] <= bus.msg_data;
        if ((r_state == S_WAIT) && bus.link_flag)
            r_dbuf[0] <= bus.link_dig;
        if (r_state == S_CAPTURE)
            r_dbuf[r_cnt] <= bus.link_dig;
    end

    assign bus.msg_ready   = (r_state == S_COLLECT);
    assign bus.busy        = (r_state != S_COLLECT);
    assign bus.link_valid  = (r_state == S_SEND);
    assign bus.link_data   = (r_state == S_SEND) ? r_buf[r_idx[c_IW-1:0]] : 8'h00;
    assign bus.dig_valid   = (r_state == S_DRAIN);
    assign bus.dig_data    = (r_state == S_DRAIN) ? r_dbuf[r_cnt] : 8'h00;
    assign bus.dig_last    = (r_state == S_DRAIN) && (r_cnt == 5'd31);
    assign bus.err_len     = r_err_len;
    assign bus.err_timeout = r_err_timeout;
endmodule
`default_nettype wire

// File: tb/tb_sha256_link_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_link_host
// Brief    : Scoreboard bench for sha256_link_host with a model hasher.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_link_host;
    localparam int MAX_LEN = 55;
    localparam int TIMEOUT = 1023;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sha256_link_host_if bus();

    sha256_link_host #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [7:0] exp_link[$];
    logic [8:0] exp_dig[$];
    logic [7:0] tx [0:127];
    logic [7:0] dg [0:31];
    logic [255:0] abc_digest = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    bit respond = 1'b0;
    bit toggle_ready = 1'b0;
    int burst_len = 0, last_burst = 0, wait_cyc = 0, flag_cyc = 0, dv_cyc = 0;
    int n_err_len = 0, n_err_tmo = 0, err_tmo_cyc = 0;
    bit lv_prev = 1'b0, dv_prev = 1'b0, prev_stall = 1'b0, h_seen = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic [8:0] ed;
    logic [7:0] el;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Link monitor: every strobed byte must match the next expected byte.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.link_valid) begin
                burst_len++;
                if (exp_link.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL link_extra: got %0h expected none", bus.link_data);
                end else begin
                    el = exp_link.pop_front();
                    check("link_data", {24'd0, bus.link_data}, {24'd0, el});
                end
            end else if (lv_prev) begin
                last_burst = burst_len;
                burst_len  = 0;
                wait_cyc   = cyc;
            end
            lv_prev = bus.link_valid;
        end
    end

    // Digest monitor: ordered pop on each handshake, stability while stalled.
    initial begin
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                check("dig_hold_valid", {31'd0, bus.dig_valid}, 32'd1);
                check("dig_hold_data", {24'd0, bus.dig_data}, {24'd0, hold_data});
            end
            if (bus.dig_valid && !dv_prev) dv_cyc = cyc;
            if (bus.dig_valid && bus.dig_ready) begin
                if (exp_dig.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL dig_extra: got %0h expected none", bus.dig_data);
                end else begin
                    ed = exp_dig.pop_front();
                    check("dig_data", {24'd0, bus.dig_data}, {24'd0, ed[7:0]});
                    check("dig_last", {31'd0, bus.dig_last}, {31'd0, ed[8]});
                end
            end
            prev_stall = bus.dig_valid && !bus.dig_ready;
            hold_data  = bus.dig_data;
            dv_prev    = bus.dig_valid;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.err_len) n_err_len++;
            if (bus.err_timeout) begin
                n_err_tmo++;
                err_tmo_cyc = cyc;
            end
        end
    end

    // Model hasher: flag only on the first digest byte, then 31 more bytes.
    initial begin
        bus.link_flag = 1'b0;
        bus.link_dig  = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.link_valid) h_seen = 1'b1;
            else if (h_seen) begin
                h_seen = 1'b0;
                if (respond) begin
                    repeat (4) @(negedge clk);
                    bus.link_flag = 1'b1;
                    bus.link_dig  = dg[0];
                    flag_cyc      = cyc;
                    for (int i = 1; i < 32; i++) begin
                        @(negedge clk);
                        bus.link_flag = 1'b0;
                        bus.link_dig  = dg[i];
                    end
                    @(negedge clk);
                    bus.link_dig = 8'h00;
                end
            end
        end
    end

    initial begin
        bus.dig_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.dig_ready = toggle_ready ? ~bus.dig_ready : 1'b1;
        end
    end

    task automatic send(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.msg_data  = tx[i];
            bus.msg_valid = 1'b1;
            bus.msg_last  = (i == n - 1);
        end
        @(negedge clk);
        bus.msg_valid = 1'b0;
        bus.msg_last  = 1'b0;
        bus.msg_data  = 8'h00;
    endtask

    task automatic run_msg(input string name, input int n, input bit resp);
        for (int i = 0; i < n; i++) exp_link.push_back(tx[i]);
        respond = resp;
        if (resp) for (int i = 0; i < 32; i++) exp_dig.push_back({(i == 31), dg[i]});
        send(n);
        check({name, "_link_latency"}, {31'd0, bus.link_valid}, 32'd1);
    endtask

    task automatic wait_idle(input string name, input int max);
        int k = 0;
        while (bus.busy && k < max) begin
            @(negedge clk);
            k++;
        end
        check({name, "_idle"}, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic check_reset(input string name);
        check({name, "_msg_ready"}, {31'd0, bus.msg_ready}, 32'd1);
        check({name, "_link"}, {23'd0, bus.link_valid, bus.link_data}, 32'd0);
        check({name, "_dig"}, {22'd0, bus.dig_valid, bus.dig_last, bus.dig_data}, 32'd0);
        check({name, "_status"}, {29'd0, bus.busy, bus.err_len, bus.err_timeout}, 32'd0);
    endtask

    task automatic check_done(input string name, input int n);
        check({name, "_burst_len"}, last_burst, n);
        check({name, "_dig_latency"}, dv_cyc - flag_cyc, 32'd32);
        check({name, "_queues_empty"}, exp_link.size() + exp_dig.size(), 32'd0);
    endtask

    task automatic load_abc();
        tx[0] = 8'h61; tx[1] = 8'h62; tx[2] = 8'h63;
        for (int i = 0; i < 32; i++) dg[i] = abc_digest[255 - 8*i -: 8];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int e0;

    initial begin
        bus.msg_data  = 8'h00;
        bus.msg_valid = 1'b0;
        bus.msg_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check_reset("rst_release");

        // "abc" with the real digest
        load_abc();
        run_msg("abc", 3, 1'b1);
        wait_idle("abc", 200);
        check_done("abc", 3);

        // Longest legal message
        for (int i = 0; i < 55; i++) tx[i] = 8'(i * 3 + 1);
        for (int i = 0; i < 32; i++) dg[i] = 8'(8'hA0 ^ i);
        run_msg("len55", 55, 1'b1);
        wait_idle("len55", 300);
        check_done("len55", 55);

        // One byte too long: rejected, nothing sent
        for (int i = 0; i < 56; i++) tx[i] = 8'(i + 8'h40);
        e0 = n_err_len;
        send(56);
        check("len56_err_len", {31'd0, bus.err_len}, 32'd1);
        check("len56_link_valid", {31'd0, bus.link_valid}, 32'd0);
        check("len56_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        check("len56_err_pulse", {31'd0, bus.err_len}, 32'd0);
        check("len56_err_count", n_err_len - e0, 32'd1);

        // Deep overflow then a short message proves len was cleared
        for (int i = 0; i < 70; i++) tx[i] = 8'(i);
        send(70);
        check("len70_err_len", {31'd0, bus.err_len}, 32'd1);
        tx[0] = 8'hC3; tx[1] = 8'h3C;
        for (int i = 0; i < 32; i++) dg[i] = 8'(255 - i);
        run_msg("after_ovf", 2, 1'b1);
        wait_idle("after_ovf", 200);
        check_done("after_ovf", 2);

        // Single-byte message with downstream back-pressure every other cycle
        tx[0] = 8'h5A;
        for (int i = 0; i < 32; i++) dg[i] = 8'(i * 5 + 7);
        toggle_ready = 1'b1;
        run_msg("len1_stall", 1, 1'b1);
        wait_idle("len1_stall", 300);
        check_done("len1_stall", 1);
        toggle_ready = 1'b0;

        // Hasher never answers
        tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33;
        e0 = n_err_tmo;
        run_msg("timeout", 3, 1'b0);
        wait_idle("timeout", TIMEOUT + 50);
        @(negedge clk);
        check("timeout_delay", err_tmo_cyc - wait_cyc, TIMEOUT);
        check("timeout_count", n_err_tmo - e0, 32'd1);
        load_abc();
        run_msg("post_timeout", 3, 1'b1);
        wait_idle("post_timeout", 200);
        check_done("post_timeout", 3);

        // Reset in the second cycle of a 10-byte burst
        for (int i = 0; i < 10; i++) tx[i] = 8'(8'h80 + i);
        run_msg("rst_send", 10, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_link_valid", {31'd0, bus.link_valid}, 32'd0);
        check_reset("rst_mid");
        exp_link.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load_abc();
        run_msg("post_rst", 3, 1'b1);
        wait_idle("post_rst", 200);
        check_done("post_rst", 3);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
